// File: rtl/spi_master_tx_fifo.sv
// Show-ahead transmit FIFO between the register write path and the SPI shifter.
// Full/empty come from the level counter only. Error flags are sticky until clr or rst.
module spi_master_tx_fifo #(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 8,
  parameter int AF_THRESHOLD = 6
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [DATA_WIDTH-1:0]           data,
  output logic                            data_valid,
  input  logic                            data_ready,
  output logic [$clog2(BUFFER_DEPTH):0]   elements,
  output logic                            almost_full,
  output logic                            ovf_err,
  output logic                            udf_err
);

  localparam int LOG_D = $clog2(BUFFER_DEPTH);
  localparam logic [LOG_D:0]   FULL_LVL = (LOG_D+1)'(BUFFER_DEPTH);
  localparam logic [LOG_D:0]   AF_LVL   = (LOG_D+1)'(AF_THRESHOLD);
  localparam logic [LOG_D:0]   ONE_LVL  = (LOG_D+1)'(1);
  localparam logic [LOG_D:0]   ZERO_LVL = (LOG_D+1)'(0);
  localparam logic [LOG_D-1:0] ONE_PTR  = LOG_D'(1);
  localparam logic [LOG_D-1:0] ZERO_PTR = LOG_D'(0);

  logic [DATA_WIDTH-1:0] mem_r [BUFFER_DEPTH];
  logic [LOG_D-1:0]      rd_ptr_r;
  logic [LOG_D-1:0]      wr_ptr_r;
  logic [LOG_D:0]        elements_r;
  logic                  ovf_r;
  logic                  udf_r;
  logic                  full_s;
  logic                  empty_s;
  logic                  push_s;
  logic                  pop_s;

  assign full_s      = (elements_r == FULL_LVL);
  assign empty_s     = (elements_r == ZERO_LVL);
  assign push_s      = in_valid && !full_s;
  assign pop_s       = data_ready && !empty_s;

  assign in_ready    = !full_s;
  assign data_valid  = !empty_s;
  assign almost_full = (elements_r >= AF_LVL);
  assign elements    = elements_r;
  assign data        = mem_r[rd_ptr_r];
  assign ovf_err     = ovf_r;
  assign udf_err     = udf_r;

  // Storage array: no reset, written only on an accepted push outside flush/reset.
  always_ff @(posedge clk) begin
    if (push_s && !rst && !clr) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // Pointers, level counter and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_ptr_r   <= ZERO_PTR;
      wr_ptr_r   <= ZERO_PTR;
      elements_r <= ZERO_LVL;
      ovf_r      <= 1'b0;
      udf_r      <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_PTR;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_PTR;
      end
      case ({push_s, pop_s})
        2'b10:   elements_r <= elements_r + ONE_LVL;
        2'b01:   elements_r <= elements_r - ONE_LVL;
        default: elements_r <= elements_r;
      endcase
      if (in_valid && full_s) begin
        ovf_r <= 1'b1;
      end
      if (data_ready && empty_s) begin
        udf_r <= 1'b1;
      end
    end
  end

endmodule
